// File: rtl/ad_serial_rx.sv
// ad_serial_rx: dual-lane serial ADC controller and deserializer.
// Issues the load strobe, drives the serial clock, and returns each X/Y word pair with a valid pulse.
module ad_serial_rx #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 2,
  parameter int LOAD_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              auto_i,
  output logic              ad_data_en_o,
  output logic              ad_sclk_o,
  input  logic              ad_sd2_i,
  input  logic              ad_sd3_i,
  output logic [DATA_W-1:0] vx_o,
  output logic [DATA_W-1:0] vy_o,
  output logic              data_valid_o,
  output logic              busy_o
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int LW = $clog2(LOAD_CYC) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [LW-1:0] lcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_W-1:0] sx, sy, nx, ny;
  logic wrap, fall, last;
  assign wrap = div == DW'(CLK_DIV - 1);
  // Sample on the sclk falling edge, a full half-period after the ADC updated its lanes.
  assign fall = wrap && ad_sclk_o;
  assign last = bcnt == BW'(DATA_W - 1);
  assign nx = {sx[DATA_W-2:0], ad_sd2_i};
  assign ny = {sy[DATA_W-2:0], ad_sd3_i};
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      div          <= '0;
      lcnt         <= '0;
      bcnt         <= '0;
      sx           <= '0;
      sy           <= '0;
      vx_o         <= '0;
      vy_o         <= '0;
      ad_data_en_o <= 1'b0;
      ad_sclk_o    <= 1'b0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i | auto_i) begin
          state        <= LOAD;
          ad_data_en_o <= 1'b1;
          busy_o       <= 1'b1;
          lcnt         <= '0;
        end
        LOAD: if (lcnt == LW'(LOAD_CYC - 1)) begin
          state        <= SHIFT;
          ad_data_en_o <= 1'b0;
          div          <= '0;
          bcnt         <= '0;
        end else lcnt <= lcnt + 1'b1;
        SHIFT: begin
          div <= wrap ? '0 : div + 1'b1;
          if (wrap) ad_sclk_o <= ~ad_sclk_o;
          if (fall) begin
            sx   <= nx;
            sy   <= ny;
            bcnt <= last ? '0 : bcnt + 1'b1;
            if (last) begin
              state        <= DONE;
              vx_o         <= nx;
              vy_o         <= ny;
              data_valid_o <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= auto_i ? LOAD : IDLE;
          ad_data_en_o <= auto_i;
          busy_o       <= auto_i;
          lcnt         <= '0;
        end
        default: begin
          state        <= IDLE;
          ad_data_en_o <= 1'b0;
          ad_sclk_o    <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ad_serial_rx.sv
// tb_ad_serial_rx: directed bench for ad_serial_rx with a behavioural ADC model per instance.
// Instance 0: defaults; 1: CLK_DIV=1/LOAD_CYC=1; 2: CLK_DIV=5/LOAD_CYC=1.
module tb_ad_serial_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start[3], auto_m[3], en[3], sclk[3], valid[3], busy[3];
  logic [15:0] vx[3], vy[3], mx[3], my[3];
  int checks = 0, errs = 0, cyc = 0;
  always @(posedge clk) cyc++;
  for (genvar g = 0; g < 3; g++) begin : u
    logic sd2 = 1'b0, sd3 = 1'b0;
    logic [15:0] sx = '0, sy = '0;
    ad_serial_rx #(.DATA_W(16), .CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 5)), .LOAD_CYC(g == 0 ? 2 : 1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start[g]), .auto_i(auto_m[g]),
      .ad_data_en_o(en[g]), .ad_sclk_o(sclk[g]), .ad_sd2_i(sd2), .ad_sd3_i(sd3),
      .vx_o(vx[g]), .vy_o(vy[g]), .data_valid_o(valid[g]), .busy_o(busy[g])
    );
    always @(posedge en[g]) begin
      sx = mx[g];
      sy = my[g];
    end
    // The ADC presents the next bit, MSB first, on each sclk rising edge.
    always @(posedge sclk[g]) begin
      sd2 = sx[15];
      sd3 = sy[15];
      sx = {sx[14:0], 1'b0};
      sy = {sy[14:0], 1'b0};
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic conv(input int g, input logic [15:0] x, input logic [15:0] y,
                      input int lat, input int lc, input int high, input bit guard);
    int n, ens, highs, rises, extra;
    logic ps;
    mx[g] = x;
    my[g] = y;
    @(negedge clk) start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
    chk("busy_on", busy[g], 1);
    n = 0; ens = en[g]; highs = 0; rises = 0; ps = 1'b0;
    while (!valid[g] && n < 400) begin
      @(posedge clk); #1;
      n++;
      start[g] = guard && (n == 10 || n == 40);
      ens += en[g];
      highs += sclk[g];
      rises += (sclk[g] && !ps) ? 1 : 0;
      ps = sclk[g];
    end
    chk("latency", n, lat);
    chk("vx", vx[g], x);
    chk("vy", vy[g], y);
    chk("en_cycles", ens, lc);
    chk("sclk_rises", rises, 16);
    chk("sclk_high", highs, high);
    @(posedge clk); #1;
    chk("valid_one_cycle", valid[g], 0);
    chk("busy_after", busy[g], 0);
    chk("vx_hold", vx[g], x);
    if (guard) begin
      extra = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (en[g] || valid[g]) extra++;
      end
      chk("guard_extra", extra, 0);
    end
  endtask
  logic [15:0] wx[4] = '{16'h1111, 16'h2468, 16'hF00F, 16'h0001};
  logic [15:0] wy[4] = '{16'hEEEE, 16'h1357, 16'h0FF0, 16'h8000};
  initial begin
    int n, falls, last;
    logic ps;
    logic [31:0] ex;
    foreach (start[i]) begin
      start[i] = 1'b0; auto_m[i] = 1'b0; mx[i] = '0; my[i] = '0;
    end
    #12;
    for (int g = 0; g < 3; g++) begin
      chk("rst_en", en[g], 0);
      chk("rst_sclk", sclk[g], 0);
      chk("rst_valid", valid[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_vxvy", {vx[g], vy[g]}, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    conv(0, 16'hA5C3, 16'h3C5A, 66, 2, 32, 1'b0);
    conv(0, 16'hFFFF, 16'h0000, 66, 2, 32, 1'b0);
    conv(0, 16'h8001, 16'h7FFE, 66, 2, 32, 1'b0);
    conv(0, 16'h5A5A, 16'hC3C3, 66, 2, 32, 1'b1);
    conv(1, 16'hC0DE, 16'h0F0F, 33, 1, 16, 1'b0);
    conv(2, 16'h8421, 16'h1248, 161, 1, 80, 1'b0);
    // Continuous mode: change the model word right after each load strobe.
    mx[0] = wx[0]; my[0] = wy[0];
    @(negedge clk) auto_m[0] = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!en[0] && n < 200) begin @(posedge clk); #1; n++; end
      chk("cont_load", en[0], 1);
      ex = {wx[k], wy[k]};
      mx[0] = wx[(k + 1) % 4]; my[0] = wy[(k + 1) % 4];
      if (k == 3) auto_m[0] = 1'b0;
      n = 0;
      while (!valid[0] && n < 200) begin @(posedge clk); #1; n++; end
      chk("cont_data", {vx[0], vy[0]}, ex);
      if (k > 0) chk("cont_spacing", cyc - last, 67);
      last = cyc;
    end
    @(posedge clk); #1;
    chk("cont_idle", busy[0], 0);
    // Reset in the middle of SHIFT, with sclk high after bit 7.
    mx[0] = 16'hBEEF; my[0] = 16'h4321;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    n = 0; falls = 0; ps = 1'b0;
    while (falls < 8 && n < 200) begin
      @(posedge clk); #1; n++;
      if (ps && !sclk[0]) falls++;
      ps = sclk[0];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_sclk", sclk[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", sclk[0], 0);
    chk("mid_rst_en", en[0], 0);
    chk("mid_rst_valid", valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_vx", vx[0], 0);
    @(negedge clk) rst_n = 1'b1;
    conv(0, 16'h1234, 16'hEDCB, 66, 2, 32, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
